// File: rtl/stack_ctrl.sv
// stack_ctrl: command front-end and sequencer for a chain of shift cells
// that together form a LIFO data stack.
//
// Requests (push / pop / replace-top) arrive over a valid/ready handshake.
// Each accepted request runs IDLE -> EXEC -> DONE: the cell strobes fire
// during EXEC and the completion pulse appears during DONE, so one request
// completes every three cycles.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   op_valid/op/op_data request channel (op: 00 nop, 01 push, 10 pop, 11 replace)
//   op_ready            request accepted when op_valid && op_ready
//   tos_in              data_out of shift cell 0 (top of stack)
//   cell_data           write data to cell 0
//   push/pop            shift-down / shift-up strobes to all cells
//   data_write/data_read write / read qualifiers to all cells
//   overwrite           overwrite strobe to cell 0
//   rsp_valid/rsp_data/rsp_err  completion pulse, popped value, rejected flag
//   depth/empty/full    occupancy status
//   overflow_err/underflow_err  sticky error flags, cleared by err_clr
//
// state | meaning
// IDLE  | op_ready high, waiting for a request
// EXEC  | strobes to the cells for the latched request (one cycle)
// DONE  | rsp_valid pulse for the completed request (one cycle)

module stack_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_data,
    output logic             op_ready,
    input  logic [WIDTH-1:0] tos_in,
    output logic [WIDTH-1:0] cell_data,
    output logic             push,
    output logic             pop,
    output logic             data_write,
    output logic             data_read,
    output logic             overwrite,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [CW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             overflow_err,
    output logic             underflow_err,
    input  logic             err_clr
);

    localparam logic [1:0]    OP_NOP    = 2'b00;
    localparam logic [1:0]    OP_PUSH   = 2'b01;
    localparam logic [1:0]    OP_POP    = 2'b10;
    localparam logic [CW-1:0] DEPTH_MAX = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t        state;
    logic [1:0]    op_q;
    logic          bad_q;
    logic [CW-1:0] depth_next;

    // Depth moves only at the end of EXEC of a legal push/pop; empty/full
    // are registered from the same next value so they never lag depth.
    always_comb begin
        depth_next = depth;
        if (state == EXEC && !bad_q) begin
            if (op_q == OP_PUSH)
                depth_next = depth + CW'(1);
            else if (op_q == OP_POP)
                depth_next = depth - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            op_ready      <= 1'b1;
            op_q          <= OP_NOP;
            bad_q         <= 1'b0;
            cell_data     <= '0;
            push          <= 1'b0;
            pop           <= 1'b0;
            data_write    <= 1'b0;
            data_read     <= 1'b0;
            overwrite     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            depth         <= '0;
            empty         <= 1'b1;
            full          <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            push       <= 1'b0;
            pop        <= 1'b0;
            data_write <= 1'b0;
            data_read  <= 1'b0;
            overwrite  <= 1'b0;
            rsp_valid  <= 1'b0;

            // Clear first so a flag being set below in the same cycle wins.
            if (err_clr) begin
                overflow_err  <= 1'b0;
                underflow_err <= 1'b0;
            end

            depth <= depth_next;
            empty <= (depth_next == '0);
            full  <= (depth_next == DEPTH_MAX);

            case (state)
                IDLE: begin
                    // Strobes are decided at accept so they are registered
                    // and high for exactly the EXEC cycle.
                    if (op_valid && op != OP_NOP) begin
                        op_q     <= op;
                        state    <= EXEC;
                        op_ready <= 1'b0;
                        bad_q    <= 1'b0;
                        case (op)
                            OP_PUSH: begin
                                if (full) begin
                                    bad_q <= 1'b1;
                                end else begin
                                    push       <= 1'b1;
                                    data_write <= 1'b1;
                                    cell_data  <= op_data;
                                end
                            end
                            OP_POP: begin
                                if (empty) begin
                                    bad_q <= 1'b1;
                                end else begin
                                    pop       <= 1'b1;
                                    data_read <= 1'b1;
                                end
                            end
                            default: begin
                                if (empty) begin
                                    bad_q <= 1'b1;
                                end else begin
                                    overwrite <= 1'b1;
                                    cell_data <= op_data;
                                end
                            end
                        endcase
                    end
                end
                EXEC: begin
                    state     <= DONE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= bad_q;
                    if (bad_q) begin
                        if (op_q == OP_PUSH)
                            overflow_err <= 1'b1;
                        else
                            underflow_err <= 1'b1;
                    end else if (op_q == OP_POP) begin
                        // Cells shift at the end of this cycle, so tos_in
                        // still shows the value being popped.
                        rsp_data <= tos_in;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                    rsp_err  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             op_valid = 1'b0;
    logic [1:0]       op = OP_NOP;
    logic [WIDTH-1:0] op_data = '0;
    logic             op_ready;
    logic [WIDTH-1:0] tos_in;
    logic [WIDTH-1:0] cell_data;
    logic             push, pop, data_write, data_read, overwrite;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [CW-1:0]    depth;
    logic             empty, full;
    logic             overflow_err, underflow_err;
    logic             err_clr = 1'b0;

    stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_data(op_data),
        .op_ready(op_ready), .tos_in(tos_in), .cell_data(cell_data),
        .push(push), .pop(pop), .data_write(data_write), .data_read(data_read),
        .overwrite(overwrite), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .depth(depth), .empty(empty), .full(full),
        .overflow_err(overflow_err), .underflow_err(underflow_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Behavioural shift-cell chain; cell reset shares the controller reset.
    logic [WIDTH-1:0] cells [DEPTH];
    assign tos_in = cells[0];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) cells[i] <= '0;
        end else if (push && data_write) begin
            for (int i = DEPTH - 1; i > 0; i--) cells[i] <= cells[i-1];
            cells[0] <= cell_data;
        end else if (pop && data_read) begin
            for (int i = 0; i < DEPTH - 1; i++) cells[i] <= cells[i+1];
            cells[DEPTH-1] <= '0;
        end else if (overwrite) begin
            cells[0] <= cell_data;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        int               cyc;
        logic             err;
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    dep;
    } exp_t;

    exp_t             sb [$];
    exp_t             e_in, e_out;
    logic [WIDTH-1:0] ref_q [$];
    logic [WIDTH-1:0] last_pop = '0;
    int               acc_cyc [$];
    int               cyc = 0;
    bit               exec_chk = 0;
    logic [4:0]       exp_strb = '0;
    bit               exp_cd_chk = 0;
    logic [WIDTH-1:0] exp_cd = '0;

    // Monitor: sampled on the falling edge, so inputs and op_ready seen here
    // are what the next rising edge will use.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_spurious", 32'd1, 32'd0);
                end else begin
                    e_out = sb.pop_front();
                    chk("rsp_latency", cyc - e_out.cyc, 32'd2);
                    chk("rsp_err", rsp_err, e_out.err);
                    chk("rsp_data", rsp_data, e_out.data);
                    chk("rsp_depth", depth, e_out.dep);
                    chk("rsp_empty_full", {empty, full},
                        {e_out.dep == 0, e_out.dep == CW'(DEPTH)});
                end
            end
            if (exec_chk) begin
                chk("strobes", {push, pop, data_write, data_read, overwrite}, exp_strb);
                if (exp_cd_chk) chk("cell_data", cell_data, exp_cd);
                exec_chk = 0;
            end
            if (reset) begin
                sb.delete();
                ref_q.delete();
                last_pop = '0;
                exec_chk = 0;
            end else if (op_valid && op_ready && op != OP_NOP) begin
                e_in.cyc = cyc;
                e_in.err = 1'b0;
                exp_strb = '0;
                exp_cd_chk = 0;
                case (op)
                    OP_PUSH: begin
                        if (ref_q.size() == DEPTH) e_in.err = 1'b1;
                        else begin
                            ref_q.push_front(op_data);
                            exp_strb = 5'b10100;
                            exp_cd_chk = 1;
                            exp_cd = op_data;
                        end
                    end
                    OP_POP: begin
                        if (ref_q.size() == 0) e_in.err = 1'b1;
                        else begin
                            last_pop = ref_q.pop_front();
                            exp_strb = 5'b01010;
                        end
                    end
                    default: begin
                        if (ref_q.size() == 0) e_in.err = 1'b1;
                        else begin
                            ref_q[0] = op_data;
                            exp_strb = 5'b00001;
                            exp_cd_chk = 1;
                            exp_cd = op_data;
                        end
                    end
                endcase
                e_in.data = last_pop;
                e_in.dep = CW'(ref_q.size());
                sb.push_back(e_in);
                acc_cyc.push_back(cyc);
                exec_chk = 1;
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic [WIDTH-1:0] d);
        bit got;
        got = 0;
        @(posedge clk); #1;
        op_valid = 1'b1; op = o; op_data = d;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (op_ready) got = 1;
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        op_valid = 1'b0; op = OP_NOP; op_data = '0;
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        bit got;

        do_reset();
        chk("rst_ready", op_ready, 32'd1);
        chk("rst_strobes", {push, pop, data_write, data_read, overwrite}, 32'd0);
        chk("rst_depth", depth, 32'd0);
        chk("rst_empty_full", {empty, full}, 32'b10);
        chk("rst_rsp", {rsp_valid, rsp_err}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_cell_data", cell_data, 32'd0);
        chk("rst_err_flags", {overflow_err, underflow_err}, 32'd0);

        // Basic pushes, pops and replace.
        send(OP_PUSH, 16'h1111);
        send(OP_PUSH, 16'h2222);
        send(OP_PUSH, 16'h3333);
        chk("push3_depth", depth, 32'd3);
        chk("push3_tos", tos_in, 32'h3333);
        chk("push3_empty", empty, 32'd0);
        send(OP_NOP, 16'h7777);
        chk("nop_depth", depth, 32'd3);
        send(OP_POP, '0);
        send(OP_POP, '0);
        chk("pop2_depth", depth, 32'd1);
        chk("pop2_rsp_data", rsp_data, 32'h2222);
        send(OP_REPL, 16'hABCD);
        chk("repl_tos", tos_in, 32'hABCD);
        chk("repl_depth", depth, 32'd1);
        chk("repl_rsp_data_held", rsp_data, 32'h2222);

        // Fill to DEPTH, then overflow.
        do_reset();
        for (int i = 0; i < DEPTH; i++) send(OP_PUSH, 16'h0100 + 16'(i));
        chk("fill_depth", depth, DEPTH);
        chk("fill_full", full, 32'd1);
        send(OP_PUSH, 16'hDEAD);
        chk("ovf_flag", overflow_err, 32'd1);
        chk("ovf_depth", depth, DEPTH);
        chk("ovf_tos", tos_in, 32'h0107);
        for (int i = 0; i < DEPTH; i++) send(OP_POP, '0);
        chk("drain_empty", {empty, full}, 32'b10);

        // Underflow and flag clear.
        send(OP_POP, '0);
        send(OP_REPL, 16'h5555);
        chk("unf_flag", underflow_err, 32'd1);
        chk("unf_depth", depth, 32'd0);
        chk("unf_tos", tos_in, 32'd0);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        chk("err_clr_flags", {overflow_err, underflow_err}, 32'd0);

        // Back-to-back pushes with op_valid held high.
        n0 = acc_cyc.size();
        @(posedge clk); #1;
        op_valid = 1'b1; op = OP_PUSH;
        for (int k = 0; k < 4; k++) begin
            op_data = 16'hB000 + 16'(k);
            got = 0;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                if (op_ready) got = 1;
            end
            if (!got) chk("b2b_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        op_valid = 1'b0; op = OP_NOP;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_count", acc_cyc.size() - n0, 32'd4);
        if (acc_cyc.size() - n0 == 4)
            for (int k = 1; k < 4; k++)
                chk("b2b_gap", acc_cyc[n0+k] - acc_cyc[n0+k-1], 32'd3);
        chk("b2b_depth", depth, 32'd4);
        for (int k = 0; k < 4; k++) send(OP_POP, '0);
        chk("b2b_last_pop", rsp_data, 32'hB000);

        // Reset during EXEC of a push.
        send(OP_PUSH, 16'h4444);
        @(posedge clk); #1;
        op_valid = 1'b1; op = OP_PUSH; op_data = 16'h9999;
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (op_ready) got = 1;
        end
        if (!got) chk("abort_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        op_valid = 1'b0; op = OP_NOP; op_data = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", op_ready, 32'd1);
        chk("abort_depth", depth, 32'd0);
        chk("abort_strobes", {push, pop, data_write, data_read, overwrite}, 32'd0);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 32'd0);
        end
        chk("abort_tos", tos_in, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
